// File: rtl/pong_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pong_game_ctrl
// Purpose  : Game sequencing for pong: serve hold, play gating, paddle shrink,
//            lives and BCD hit score. All outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
    parameter int LIVES         = 3,
    parameter int SERVE_FRAMES  = 60,
    parameter int SHRINK_FRAMES = 1800,
    parameter int BAR_SIZE_INIT = 280,
    parameter int BAR_SIZE_MIN  = 35
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       refr_tick,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic       ball_reset,
    output logic       play_en,
    output logic [1:0] serve_dir,
    output logic [8:0] bar_size,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       game_over
);

    localparam int FRAME_W  = (SERVE_FRAMES  > 1) ? $clog2(SERVE_FRAMES)  : 1;
    localparam int SHRINK_W = (SHRINK_FRAMES > 1) ? $clog2(SHRINK_FRAMES) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SERVE = 3'd1;
    localparam logic [2:0] PLAY  = 3'd2;
    localparam logic [2:0] MISS  = 3'd3;
    localparam logic [2:0] OVER  = 3'd4;

    localparam logic [FRAME_W-1:0]  C_FRAME_LOAD = FRAME_W'(SERVE_FRAMES - 1);
    localparam logic [SHRINK_W-1:0] C_SHRINK_END = SHRINK_W'(SHRINK_FRAMES - 1);
    localparam logic [8:0]          C_BAR_INIT   = 9'(BAR_SIZE_INIT);
    localparam logic [8:0]          C_BAR_MIN    = 9'(BAR_SIZE_MIN);

    logic [2:0]          r_state;
    logic [FRAME_W-1:0]  r_frame_cnt;
    logic [SHRINK_W-1:0] r_shrink_cnt;
    logic                r_start_prev;
    logic                r_hit_prev;

    logic       w_start_rise;
    logic       w_hit_rise;
    logic [8:0] w_bar_half;
    logic [7:0] w_score_inc;

    assign w_start_rise = start & ~r_start_prev;
    assign w_hit_rise   = hit & ~r_hit_prev;
    assign w_bar_half   = ((bar_size >> 1) < C_BAR_MIN) ? C_BAR_MIN : (bar_size >> 1);

    // Two-digit BCD increment that saturates at 99.
    always_comb begin
        w_score_inc = score;
        if (score != 8'h99) begin
            if (score[3:0] == 4'd9) begin
                w_score_inc = {score[7:4] + 4'd1, 4'd0};
            end else begin
                w_score_inc = {score[7:4], score[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_frame_cnt  <= '0;
            r_shrink_cnt <= '0;
            r_start_prev <= 1'b1;
            r_hit_prev   <= 1'b1;
            ball_reset   <= 1'b1;
            play_en      <= 1'b0;
            serve_dir    <= 2'd0;
            bar_size     <= C_BAR_INIT;
            lives        <= 2'd0;
            score        <= 8'h00;
            game_over    <= 1'b0;
        end else begin
            r_start_prev <= start;
            r_hit_prev   <= hit;
            case (r_state)
                IDLE, OVER: begin
                    if (w_start_rise) begin
                        r_state      <= SERVE;
                        r_frame_cnt  <= C_FRAME_LOAD;
                        r_shrink_cnt <= '0;
                        lives        <= 2'(LIVES);
                        score        <= 8'h00;
                        bar_size     <= C_BAR_INIT;
                        serve_dir    <= 2'd0;
                        ball_reset   <= 1'b1;
                        play_en      <= 1'b0;
                        game_over    <= 1'b0;
                    end
                end
                SERVE: begin
                    if (refr_tick) begin
                        if (r_frame_cnt == '0) begin
                            r_state    <= PLAY;
                            ball_reset <= 1'b0;
                            play_en    <= 1'b1;
                        end else begin
                            r_frame_cnt <= r_frame_cnt - 1'b1;
                        end
                    end
                end
                PLAY: begin
                    // A miss pre-empts any same-cycle hit edge or shrink step.
                    if (miss) begin
                        r_state <= MISS;
                        play_en <= 1'b0;
                    end else begin
                        if (refr_tick) begin
                            if (r_shrink_cnt == C_SHRINK_END) begin
                                r_shrink_cnt <= '0;
                                bar_size     <= w_bar_half;
                            end else begin
                                r_shrink_cnt <= r_shrink_cnt + 1'b1;
                            end
                        end
                        if (w_hit_rise) begin
                            score <= w_score_inc;
                        end
                    end
                end
                MISS: begin
                    lives        <= lives - 2'd1;
                    serve_dir    <= serve_dir + 2'd1;
                    bar_size     <= C_BAR_INIT;
                    r_shrink_cnt <= '0;
                    ball_reset   <= 1'b1;
                    play_en      <= 1'b0;
                    if (lives == 2'd1) begin
                        r_state   <= OVER;
                        game_over <= 1'b1;
                    end else begin
                        r_state     <= SERVE;
                        r_frame_cnt <= C_FRAME_LOAD;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    ball_reset <= 1'b1;
                    play_en    <= 1'b0;
                    game_over  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pong_game_ctrl
// Purpose  : Randomised scoreboard bench for pong_game_ctrl against a
//            frame/score-counting reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    localparam int LIVES = 3, SERVE_FRAMES = 60, SHRINK_FRAMES = 1800;
    localparam int BAR_INIT = 280, BAR_MIN = 35;

    logic clk = 1'b0, reset_n = 1'b0;
    logic refr_tick = 1'b0, start = 1'b1, hit = 1'b1, miss = 1'b0;
    logic ball_reset, play_en, game_over;
    logic [1:0] serve_dir, lives;
    logic [8:0] bar_size;
    logic [7:0] score;

    pong_game_ctrl #(
        .LIVES(LIVES), .SERVE_FRAMES(SERVE_FRAMES), .SHRINK_FRAMES(SHRINK_FRAMES),
        .BAR_SIZE_INIT(BAR_INIT), .BAR_SIZE_MIN(BAR_MIN)
    ) dut (
        .clk(clk), .reset_n(reset_n), .refr_tick(refr_tick), .start(start),
        .hit(hit), .miss(miss), .ball_reset(ball_reset), .play_en(play_en),
        .serve_dir(serve_dir), .bar_size(bar_size), .lives(lives),
        .score(score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       br;
        logic       pe;
        logic [1:0] dir;
        logic [8:0] bar;
        logic [1:0] lives;
        logic [7:0] score;
        logic       go;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, expv);
        end
    endtask

    // Reference model: game phase plus plain integer counters.
    int m_mode;   // 0 idle, 1 serve, 2 play, 3 miss, 4 over
    int m_serve_left, m_shrink, m_bar, m_lives, m_score, m_dir;
    bit m_sp, m_hp;

    function automatic void model_reset();
        m_mode = 0; m_serve_left = 0; m_shrink = 0; m_bar = BAR_INIT;
        m_lives = 0; m_score = 0; m_dir = 0; m_sp = 1'b1; m_hp = 1'b1;
    endfunction

    function automatic void model_step(bit s, bit h, bit ms, bit tk);
        bit s_edge, h_edge;
        s_edge = s && !m_sp;
        h_edge = h && !m_hp;
        m_sp = s; m_hp = h;
        case (m_mode)
            0, 4: if (s_edge) begin
                m_lives = LIVES; m_score = 0; m_bar = BAR_INIT; m_dir = 0;
                m_shrink = 0; m_serve_left = SERVE_FRAMES; m_mode = 1;
            end
            1: if (tk) begin
                m_serve_left--;
                if (m_serve_left == 0) m_mode = 2;
            end
            2: if (ms) m_mode = 3;
               else begin
                   if (tk) begin
                       m_shrink++;
                       if (m_shrink == SHRINK_FRAMES) begin
                           m_shrink = 0;
                           m_bar = (m_bar / 2 < BAR_MIN) ? BAR_MIN : m_bar / 2;
                       end
                   end
                   if (h_edge && m_score < 99) m_score++;
               end
            default: begin
                m_lives--; m_dir = (m_dir + 1) % 4; m_bar = BAR_INIT; m_shrink = 0;
                if (m_lives == 0) m_mode = 4;
                else begin m_mode = 1; m_serve_left = SERVE_FRAMES; end
            end
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.br    = (m_mode == 0 || m_mode == 1 || m_mode == 4);
        e.pe    = (m_mode == 2);
        e.go    = (m_mode == 4);
        e.dir   = 2'(m_dir);
        e.bar   = 9'(m_bar);
        e.lives = 2'(m_lives);
        e.score = 8'(((m_score / 10) << 4) | (m_score % 10));
        return e;
    endfunction

    // One clock of stimulus; percentages give per-cycle input probabilities.
    task automatic cycle(input bit rst_low, input int p_tick, input int p_hit,
                         input int p_miss, input int p_start);
        @(negedge clk);
        refr_tick = ($urandom_range(99) < p_tick);
        hit       = ($urandom_range(99) < p_hit);
        miss      = ($urandom_range(99) < p_miss);
        start     = ($urandom_range(99) < p_start);
        reset_n   = !rst_low;
        if (rst_low) model_reset();
        else model_step(start, hit, miss, refr_tick);
        exp_q.push_back(model_out());
    endtask

    // Monitor: compares every registered output one step after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ball_reset", int'(ball_reset), int'(e.br));
                chk("play_en",    int'(play_en),    int'(e.pe));
                chk("serve_dir",  int'(serve_dir),  int'(e.dir));
                chk("bar_size",   int'(bar_size),   int'(e.bar));
                chk("lives",      int'(lives),      int'(e.lives));
                chk("score",      int'(score),      int'(e.score));
                chk("game_over",  int'(game_over),  int'(e.go));
            end
        end
    end

    initial begin
        model_reset();
        // Reset with start and hit already high: no edges after release.
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, 100, 0, 100);
        for (int i = 0; i < 5; i++) cycle(1'b0, 0, 100, 0, 100);
        // Launch a game, then run long uninterrupted play to saturate score and shrink.
        for (int i = 0; i < 200; i++) cycle(1'b0, 100, 50, 0, 12);
        for (int i = 0; i < 7500; i++) cycle(1'b0, 100, 40, 0, 0);

        // Asynchronous reset mid-play: outputs must change with no clock edge.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_ball_reset", int'(ball_reset), 1);
        chk("async_play_en",    int'(play_en),    0);
        chk("async_serve_dir",  int'(serve_dir),  0);
        chk("async_bar_size",   int'(bar_size),   BAR_INIT);
        chk("async_lives",      int'(lives),      0);
        chk("async_score",      int'(score),      0);
        chk("async_game_over",  int'(game_over),  0);
        for (int i = 0; i < 2; i++) cycle(1'b1, 50, 50, 50, 50);

        // Mixed random play: misses, game over, restarts, coincident miss/hit.
        for (int i = 0; i < 20000; i++) cycle(1'b0, 60, 35, 2, 4);
        for (int i = 0; i < 3000; i++) cycle(1'b0, 90, 50, 1, 2);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
